axil_rec_packer: RTL

- Sits directly downstream of the AXI-Lite master recorder.
- Consumes one record bundle per handshake: per-channel present/busy header plus AW address, W data/strobe and AR address.
- Serializes each record into a stream of fixed-width log words (one header word, then one word per present channel) for the record/replay log writer.
- Provides back-pressure to the recorder and counts emitted records.

---
 rtl/axil_rr_pkg.sv | 31 +++
 rtl/axil_rec_packer_if.sv | 34 +++
 rtl/axil_rec_next_chan.sv | 43 ++++
 rtl/axil_rec_packer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/axil_rr_pkg.sv
// Shared definitions for the AXI-Lite record/replay path: channel indices,
// log header field layout, record FSM states and the channel word-count helper.
package axil_rr_pkg;

    localparam int NUM_CH = 3;
    localparam int CH_AW  = 0;
    localparam int CH_W   = 1;
    localparam int CH_AR  = 2;

    // Header word: [2:0] pkt, [5:3] busy, [7:6] payload word count, then seq.
    localparam int HDR_PKT_LSB  = 0;
    localparam int HDR_BUSY_LSB = 3;
    localparam int HDR_CNT_LSB  = 6;
    localparam int HDR_CNT_W    = 2;
    localparam int HDR_SEQ_LSB  = 8;

    typedef logic [NUM_CH-1:0] chan_mask_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_AW,
        ST_W,
        ST_AR
    } state_e;

    function automatic logic [HDR_CNT_W-1:0] chan_count(input chan_mask_t pkt);
        return HDR_CNT_W'(pkt[CH_AW]) + HDR_CNT_W'(pkt[CH_W]) + HDR_CNT_W'(pkt[CH_AR]);
    endfunction

endpackage

// File: rtl/axil_rec_packer_if.sv
// Record-in and log-word-out handshakes of the record packer. The slave
// modport is the packer; the master modport is the recorder plus log sink.
interface axil_rec_packer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OUT_W  = 64
) ();

    localparam int W_W = DATA_W + DATA_W / 8;

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_pkt;
    logic [2:0]        in_busy;
    logic [ADDR_W-1:0] in_aw;
    logic [W_W-1:0]    in_w;
    logic [ADDR_W-1:0] in_ar;

    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;

    modport slave (
        input  in_valid, in_pkt, in_busy, in_aw, in_w, in_ar, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_pkt, in_busy, in_aw, in_w, in_ar, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/axil_rec_next_chan.sv
// Picks the next word slot of a record (HDR -> AW -> W -> AR, skipping absent
// channels) and flags whether that slot is the record's final word.
module axil_rec_next_chan
    import axil_rr_pkg::*;
(
    input  state_e     cur,
    input  chan_mask_t pkt,
    output state_e     nxt,
    output logic       last
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        nxt  = ST_IDLE;
        last = 1'b0;

        case (cur)
            ST_IDLE: nxt = ST_HDR;
            ST_HDR: begin
                if (pkt[CH_AW])      nxt = ST_AW;
                else if (pkt[CH_W])  nxt = ST_W;
                else if (pkt[CH_AR]) nxt = ST_AR;
            end
            ST_AW: begin
                if (pkt[CH_W])       nxt = ST_W;
                else if (pkt[CH_AR]) nxt = ST_AR;
            end
            ST_W: begin
                if (pkt[CH_AR])      nxt = ST_AR;
            end
            default: nxt = ST_IDLE;
        endcase

        case (nxt)
            ST_HDR:  last = (pkt == '0);
            ST_AW:   last = !pkt[CH_W] && !pkt[CH_AR];
            ST_W:    last = !pkt[CH_AR];
            ST_AR:   last = 1'b1;
            default: last = 1'b0;
        endcase
    end

endmodule

// File: rtl/axil_rec_packer.sv
// Serializes recorder bundles into a header word plus one word per present
// channel, with AXI-Stream style back-pressure and a completed-record counter.
module axil_rec_packer
    import axil_rr_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OUT_W  = 64,
    parameter int SEQ_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    axil_rec_packer_if.slave    bus,
    output logic [31:0]         rec_cnt
);

    localparam int W_W = DATA_W + DATA_W / 8;

    state_e            state_q,     state_d;
    chan_mask_t        pkt_q,       pkt_d;
    logic [ADDR_W-1:0] aw_q,        aw_d;
    logic [W_W-1:0]    w_q,         w_d;
    logic [ADDR_W-1:0] ar_q,        ar_d;
    logic [SEQ_W-1:0]  seq_q,       seq_d;
    logic [31:0]       rec_cnt_q,   rec_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;
    logic [OUT_W-1:0]  out_data_q,  out_data_d;

    state_e nxt_state;
    logic   nxt_last;
    logic   in_ready;
    logic   out_hs;
    logic   accept;

    axil_rec_next_chan u_next_chan (
        .cur  (state_q),
        .pkt  (pkt_q),
        .nxt  (nxt_state),
        .last (nxt_last)
    );

    function automatic logic [OUT_W-1:0] make_hdr(
        input chan_mask_t       pkt,
        input chan_mask_t       busy,
        input logic [SEQ_W-1:0] seq
    );
        logic [OUT_W-1:0] h;
        h = '0;
        h[HDR_PKT_LSB  +: NUM_CH]    = pkt;
        h[HDR_BUSY_LSB +: NUM_CH]    = busy;
        h[HDR_CNT_LSB  +: HDR_CNT_W] = chan_count(pkt);
        h[HDR_SEQ_LSB  +: SEQ_W]     = seq;
        return h;
    endfunction

    assign out_hs   = out_valid_q && bus.out_ready;
    assign in_ready = (state_q == ST_IDLE) || (out_hs && out_last_q);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        pkt_d       = pkt_q;
        aw_d        = aw_q;
        w_d         = w_q;
        ar_d        = ar_q;
        seq_d       = seq_q;
        rec_cnt_d   = rec_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if (out_hs) begin
            if (out_last_q) begin
                rec_cnt_d   = rec_cnt_q + 32'd1;
                seq_d       = seq_q + SEQ_W'(1);
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                out_data_d  = '0;
            end else begin
                state_d    = nxt_state;
                out_last_d = nxt_last;
                case (nxt_state)
                    ST_AW:   out_data_d = OUT_W'(aw_q);
                    ST_W:    out_data_d = OUT_W'(w_q);
                    ST_AR:   out_data_d = OUT_W'(ar_q);
                    default: out_data_d = '0;
                endcase
            end
        end

        // Busy bits only ever appear in the header, so they go straight into
        // the header word here; seq_d already reflects a same-cycle completion.
        if (accept) begin
            pkt_d       = bus.in_pkt;
            aw_d        = bus.in_aw;
            w_d         = bus.in_w;
            ar_d        = bus.in_ar;
            state_d     = ST_HDR;
            out_valid_d = 1'b1;
            out_last_d  = (bus.in_pkt == '0);
            out_data_d  = make_hdr(bus.in_pkt, bus.in_busy, seq_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pkt_q       <= '0;
            aw_q        <= '0;
            w_q         <= '0;
            ar_q        <= '0;
            seq_q       <= '0;
            rec_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            // NOTE: non-blocking only, so every flop samples pre-edge values.
            state_q     <= state_d;
            pkt_q       <= pkt_d;
            aw_q        <= aw_d;
            w_q         <= w_d;
            ar_q        <= ar_d;
            seq_q       <= seq_d;
            rec_cnt_q   <= rec_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign rec_cnt       = rec_cnt_q;

endmodule
